// File: rtl/mem_stage_lsu.sv
// Load/store stage behind the EX ALU: req/ack data-memory access with byte lanes and load extension.
// Optional macro MEM_ALIGN_EXC_EN: misaligned accesses are not issued and raise addr_err instead.
module mem_stage_lsu #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [3:0]  ex_mem_op,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        bus_err,
    output logic        addr_err
);

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LBU = 4'b0010;
    localparam logic [3:0] OP_LH  = 4'b0011;
    localparam logic [3:0] OP_LHU = 4'b0100;
    localparam logic [3:0] OP_LW  = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1001;
    localparam logic [3:0] OP_SH  = 4'b1010;
    localparam logic [3:0] OP_SW  = 4'b1011;
    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [4:0]  rd_q;
    logic        rw_q;
    logic        is_load, is_store, is_mem, misaligned;
    logic        accept, issue, ack_hit, timeout;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] a,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'd0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Unknown opcodes fall through both flags and behave as non-memory ops.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (ex_mem_op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: is_load  = 1'b1;
            OP_SB, OP_SH, OP_SW:                 is_store = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        req_be    = 4'b1111;
        req_wdata = ex_store_data;
        case (ex_mem_op)
            OP_LB, OP_LBU, OP_SB: req_be = 4'b0001 << ex_alu_result[1:0];
            OP_LH, OP_LHU, OP_SH: req_be = ex_alu_result[1] ? 4'b1100 : 4'b0011;
            default: ;
        endcase
        if (ex_mem_op == OP_SB)
            req_wdata = {4{ex_store_data[7:0]}};
        else if (ex_mem_op == OP_SH)
            req_wdata = {2{ex_store_data[15:0]}};
        else if (is_load)
            req_wdata = 32'd0;
    end

`ifdef MEM_ALIGN_EXC_EN
    assign misaligned = (((ex_mem_op == OP_LH) || (ex_mem_op == OP_LHU) || (ex_mem_op == OP_SH))
                         && ex_alu_result[0])
                     || (((ex_mem_op == OP_LW) || (ex_mem_op == OP_SW))
                         && (ex_alu_result[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign is_mem  = is_load || is_store;
    assign stall   = (state == BUSY);
    assign accept  = ex_valid && !stall;
    assign issue   = accept && is_mem && !misaligned;
    assign ack_hit = (state == BUSY) && mem_req && mem_ack;
    // An ack on the last allowed cycle takes priority over the abort.
    assign timeout = (state == BUSY) && !ack_hit && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (issue) state_next = BUSY;
            BUSY: if (ack_hit || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result and error outputs are single-cycle: they fall back to zero unless refreshed.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt     <= 8'd0;
            op_q         <= 4'd0;
            addr_q       <= 32'd0;
            rd_q         <= 5'd0;
            rw_q         <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_be       <= 4'd0;
            mem_wdata    <= 32'd0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            bus_err      <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_rd        <= 5'd0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            bus_err      <= 1'b0;
            addr_err     <= 1'b0;
            if (state == BUSY) wait_cnt <= wait_cnt + 8'd1;

            if (accept && !is_mem) begin
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write && (ex_rd != 5'd0);
                wb_data      <= ex_alu_result;
            end else if (accept && misaligned) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                wb_data  <= ex_alu_result;
                addr_err <= 1'b1;
            end else if (issue) begin
                wait_cnt  <= 8'd0;
                op_q      <= ex_mem_op;
                addr_q    <= ex_alu_result;
                rd_q      <= ex_rd;
                rw_q      <= ex_reg_write;
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {ex_alu_result[31:2], 2'b00};
                mem_be    <= req_be;
                mem_wdata <= req_wdata;
            end

            if (ack_hit) begin
                mem_req      <= 1'b0;
                mem_we       <= 1'b0;
                wb_valid     <= 1'b1;
                wb_rd        <= rd_q;
                wb_reg_write <= !op_q[3] && rw_q && (rd_q != 5'd0);
                wb_data      <= op_q[3] ? 32'd0 : load_extend(op_q, addr_q[1:0], mem_rdata);
            end else if (timeout) begin
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= addr_q;
                bus_err  <= 1'b1;
            end
        end
    end

endmodule
